// File: rtl/seg7_pkg.sv
// Shared glyph table, scan state encoding and sizing helper for the
// seven-segment scan driver.
package seg7_pkg;

  localparam logic [6:0] SEG_OFF = 7'b000_0000;
  localparam logic [6:0] SEG_ALL = 7'b111_1111;

  // Segment order {a,b,c,d,e,f,g}; entry n is the glyph for nibble value n.
  localparam logic [0:15][6:0] GLYPHS = {
    7'b111_1110, 7'b011_0000, 7'b110_1101, 7'b111_1001,
    7'b011_0011, 7'b101_1011, 7'b101_1111, 7'b111_0000,
    7'b111_1111, 7'b111_1011, 7'b111_0111, 7'b001_1111,
    7'b100_1110, 7'b011_1101, 7'b100_1111, 7'b100_0111
  };

  typedef enum logic {
    ST_GUARD = 1'b0,
    ST_SHOW  = 1'b1
  } state_e;

  function automatic int clog2(input int value);
    int w;
    w = 1;
    while ((1 << w) < value) w++;
    return w;
  endfunction

endpackage

// File: rtl/seg7_font.sv
// Nibble to seven-segment glyph; with HEX_MODE=0 values 10..15 light every segment.
module seg7_font
  import seg7_pkg::*;
#(
  parameter int HEX_MODE = 1
) (
  input  logic [3:0] nib,
  output logic [6:0] glyph
);

  // glyph lookup
  always_comb begin
    if ((HEX_MODE == 0) && (nib > 4'd9)) begin
      glyph = SEG_ALL;
    end else begin
      glyph = GLYPHS[nib];
    end
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed seven-segment driver: one snapshot per frame, one digit lit
// at a time with an all-off guard between digits, all outputs registered.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int SCAN_DIV       = 50000,
  parameter int GUARD_CYCLES   = 2,
  parameter int HEX_MODE       = 1,
  parameter int LZ_SUPPRESS    = 0,
  parameter int SEG_ACTIVE_LOW = 0,
  parameter int DIG_ACTIVE_LOW = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [4*NUM_DIGITS-1:0]   din,
  input  logic [NUM_DIGITS-1:0]     dp_in,
  input  logic [NUM_DIGITS-1:0]     digit_en,
  output logic [6:0]                seg,
  output logic                      dp,
  output logic [NUM_DIGITS-1:0]     dig,
  output logic                      frame_tick
);

  localparam int IDX_W   = clog2(NUM_DIGITS);
  localparam int CNT_MAX = (SCAN_DIV > GUARD_CYCLES) ? SCAN_DIV : GUARD_CYCLES;
  localparam int CNT_W   = clog2(CNT_MAX);

  localparam logic [IDX_W-1:0]      IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [CNT_W-1:0]      SHOW_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0]      GUARD_LAST = CNT_W'(GUARD_CYCLES - 1);
  localparam logic [6:0]            SEG_INV    = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic                  DP_INV     = (SEG_ACTIVE_LOW != 0);
  localparam logic [NUM_DIGITS-1:0] DIG_INV    = (DIG_ACTIVE_LOW != 0) ? '1 : '0;

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [4*NUM_DIGITS-1:0] snap_din_q, snap_din_d;
  logic [NUM_DIGITS-1:0]   snap_dp_q, snap_dp_d;
  logic [NUM_DIGITS-1:0]   snap_en_q, snap_en_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic [NUM_DIGITS-1:0]   dig_q, dig_d;
  logic                    frame_tick_q, frame_tick_d;

  logic [3:0]              nib_sel;
  logic [6:0]              glyph;
  logic [NUM_DIGITS-1:0]   upper_zero;
  logic                    suppress;

  assign nib_sel = snap_din_q[{idx_q, 2'b00} +: 4];

  seg7_font #(.HEX_MODE(HEX_MODE)) u_font (
    .nib   (nib_sel),
    .glyph (glyph)
  );

  // scan sequencer; the snapshot is taken only on the last guard cycle before digit 0
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q + CNT_W'(1);
    snap_din_d = snap_din_q;
    snap_dp_d  = snap_dp_q;
    snap_en_d  = snap_en_q;
    case (state_q)
      ST_GUARD: begin
        if (cnt_q == GUARD_LAST) begin
          state_d = ST_SHOW;
          cnt_d   = '0;
          if (idx_q == '0) begin
            snap_din_d = din;
            snap_dp_d  = dp_in;
            snap_en_d  = digit_en;
          end else begin
            snap_din_d = snap_din_q;
          end
        end else begin
          state_d = ST_GUARD;
        end
      end
      ST_SHOW: begin
        if (cnt_q == SHOW_LAST) begin
          state_d = ST_GUARD;
          cnt_d   = '0;
          idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        end else begin
          state_d = ST_SHOW;
        end
      end
      default: begin
        state_d = ST_GUARD;
        idx_d   = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // digit k is a leading zero when it and every more significant nibble are zero
  always_comb begin
    upper_zero = '0;
    upper_zero[NUM_DIGITS-1] = (snap_din_q[4*(NUM_DIGITS-1) +: 4] == 4'h0);
    for (int k = NUM_DIGITS - 2; k >= 0; k--) begin
      upper_zero[k] = upper_zero[k+1] && (snap_din_q[4*k +: 4] == 4'h0);
    end
    suppress = (LZ_SUPPRESS != 0) && (idx_q != '0) && upper_zero[idx_q];
  end

  // output image for the current scan state, polarity applied last
  always_comb begin
    seg_d        = SEG_OFF;
    dp_d         = 1'b0;
    dig_d        = '0;
    frame_tick_d = (state_q == ST_GUARD) && (idx_q == '0) && (cnt_q == '0);
    if (state_q == ST_SHOW) begin
      dig_d[idx_q] = 1'b1;
      if (snap_en_q[idx_q]) begin
        dp_d  = snap_dp_q[idx_q];
        seg_d = suppress ? SEG_OFF : glyph;
      end else begin
        dp_d  = 1'b0;
      end
    end else begin
      dig_d = '0;
    end
    seg_d = seg_d ^ SEG_INV;
    dp_d  = dp_d ^ DP_INV;
    dig_d = dig_d ^ DIG_INV;
  end

  // state, snapshot and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_GUARD;
      idx_q        <= '0;
      cnt_q        <= '0;
      snap_din_q   <= '0;
      snap_dp_q    <= '0;
      snap_en_q    <= '0;
      seg_q        <= SEG_OFF ^ SEG_INV;
      dp_q         <= DP_INV;
      dig_q        <= DIG_INV;
      frame_tick_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      snap_din_q   <= snap_din_d;
      snap_dp_q    <= snap_dp_d;
      snap_en_q    <= snap_en_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      dig_q        <= dig_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign seg        = seg_q;
  assign dp         = dp_q;
  assign dig        = dig_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed, scoreboard-based bench for seg7_scan_driver: four instances share the
// stimulus (default, legacy glyphs, leading-zero blanking, inverted pins).
module tb_seg7_scan_driver;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] din;
  logic [3:0]  dp_in;
  logic [3:0]  digit_en;

  logic [6:0]  seg_o [4];
  logic        dp_o  [4];
  logic [3:0]  dig_o [4];
  logic        ft_o  [4];

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [3:0] dig;
    logic [6:0] seg;
    logic       dp;
  } exp_t;

  exp_t sb_q[$];

  always #5 clk = ~clk;

  seg7_scan_driver #(.NUM_DIGITS(4), .SCAN_DIV(4), .GUARD_CYCLES(1), .HEX_MODE(1),
                     .LZ_SUPPRESS(0), .SEG_ACTIVE_LOW(0), .DIG_ACTIVE_LOW(0)) dut_def (
    .clk(clk), .rst(rst), .din(din), .dp_in(dp_in), .digit_en(digit_en),
    .seg(seg_o[0]), .dp(dp_o[0]), .dig(dig_o[0]), .frame_tick(ft_o[0]));

  seg7_scan_driver #(.NUM_DIGITS(4), .SCAN_DIV(4), .GUARD_CYCLES(1), .HEX_MODE(0),
                     .LZ_SUPPRESS(0), .SEG_ACTIVE_LOW(0), .DIG_ACTIVE_LOW(0)) dut_leg (
    .clk(clk), .rst(rst), .din(din), .dp_in(dp_in), .digit_en(digit_en),
    .seg(seg_o[1]), .dp(dp_o[1]), .dig(dig_o[1]), .frame_tick(ft_o[1]));

  seg7_scan_driver #(.NUM_DIGITS(4), .SCAN_DIV(4), .GUARD_CYCLES(1), .HEX_MODE(1),
                     .LZ_SUPPRESS(1), .SEG_ACTIVE_LOW(0), .DIG_ACTIVE_LOW(0)) dut_lz (
    .clk(clk), .rst(rst), .din(din), .dp_in(dp_in), .digit_en(digit_en),
    .seg(seg_o[2]), .dp(dp_o[2]), .dig(dig_o[2]), .frame_tick(ft_o[2]));

  seg7_scan_driver #(.NUM_DIGITS(4), .SCAN_DIV(4), .GUARD_CYCLES(1), .HEX_MODE(1),
                     .LZ_SUPPRESS(0), .SEG_ACTIVE_LOW(1), .DIG_ACTIVE_LOW(1)) dut_inv (
    .clk(clk), .rst(rst), .din(din), .dp_in(dp_in), .digit_en(digit_en),
    .seg(seg_o[3]), .dp(dp_o[3]), .dig(dig_o[3]), .frame_tick(ft_o[3]));

  function automatic logic [6:0] glyph_model(input logic [3:0] v, input bit hex);
    case (v)
      4'h0: return 7'b1111110;
      4'h1: return 7'b0110000;
      4'h2: return 7'b1101101;
      4'h3: return 7'b1111001;
      4'h4: return 7'b0110011;
      4'h5: return 7'b1011011;
      4'h6: return 7'b1011111;
      4'h7: return 7'b1110000;
      4'h8: return 7'b1111111;
      4'h9: return 7'b1111011;
      4'hA: return hex ? 7'b1110111 : 7'b1111111;
      4'hB: return hex ? 7'b0011111 : 7'b1111111;
      4'hC: return hex ? 7'b1001110 : 7'b1111111;
      4'hD: return hex ? 7'b0111101 : 7'b1111111;
      4'hE: return hex ? 7'b1001111 : 7'b1111111;
      default: return hex ? 7'b1000111 : 7'b1111111;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected logical view of one frame, digit 0 first.
  task automatic push_frame(input logic [15:0] d, input logic [3:0] dpv,
                            input logic [3:0] en, input bit hex, input bit lz);
    exp_t e;
    for (int k = 0; k < 4; k++) begin
      e.dig = 4'b0001 << k;
      if (!en[k]) begin
        e.seg = 7'b0000000;
        e.dp  = 1'b0;
      end else begin
        e.dp  = dpv[k];
        e.seg = (lz && (k > 0) && ((d >> (4 * k)) == 16'h0)) ? 7'b0000000
                                                             : glyph_model(d[4*k +: 4], hex);
      end
      sb_q.push_back(e);
    end
  endtask

  // Waits (bounded) for frame_tick on instance sel, then checks one whole frame.
  task automatic check_frame(input int sel, input bit chg, input logic [15:0] chg_val);
    exp_t e;
    int   n;
    bit   inv;
    inv = (sel == 3);
    n = 0;
    while (ft_o[sel] !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("frame_tick_seen", 32'(ft_o[sel]), 32'd1);
    if (ft_o[sel] !== 1'b1) return;
    chk("tick_guard_dig", 32'(dig_o[sel]), 32'(inv ? 4'hF : 4'h0));
    for (int d = 0; d < 4; d++) begin
      if (sb_q.size() == 0) begin
        chk("scoreboard_empty", 32'd0, 32'd1);
        return;
      end
      e = sb_q.pop_front();
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        if (chg && d == 2 && c == 1) din = chg_val;
        chk("show_dig", 32'(dig_o[sel]), 32'(e.dig ^ {4{inv}}));
        chk("show_seg", 32'(seg_o[sel]), 32'(e.seg ^ {7{inv}}));
        chk("show_dp",  32'(dp_o[sel]),  32'(e.dp ^ inv));
      end
      @(negedge clk);
      chk("guard_dig", 32'(dig_o[sel]), 32'(inv ? 4'hF : 4'h0));
      chk("guard_tick", 32'(ft_o[sel]), 32'(d == 3));
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b1;
    din      = 16'h1234;
    dp_in    = 4'h0;
    digit_en = 4'hF;

    // Reset held three cycles; logical and inverted reset values.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_dig", 32'(dig_o[0]), 32'h0);
    chk("rst_seg", 32'(seg_o[0]), 32'h0);
    chk("rst_dp",  32'(dp_o[0]),  32'h0);
    chk("rst_tick", 32'(ft_o[0]), 32'h0);
    chk("rst_inv_seg", 32'(seg_o[3]), 32'h7F);
    chk("rst_inv_dp",  32'(dp_o[3]),  32'h1);
    chk("rst_inv_dig", 32'(dig_o[3]), 32'hF);
    rst = 1'b0;
    @(negedge clk);
    chk("first_tick", 32'(ft_o[0]), 32'd1);

    // Scan order and digits, two consecutive frames.
    push_frame(16'h1234, 4'h0, 4'hF, 1'b1, 1'b0);
    check_frame(0, 1'b0, 16'h0);
    push_frame(16'h1234, 4'h0, 4'hF, 1'b1, 1'b0);
    check_frame(0, 1'b0, 16'h0);

    // Hex glyphs, then the same frame stream on the legacy-glyph instance.
    din = 16'hFA0B;
    do_reset();
    push_frame(16'hFA0B, 4'h0, 4'hF, 1'b1, 1'b0);
    check_frame(0, 1'b0, 16'h0);
    push_frame(16'hFA0B, 4'h0, 4'hF, 1'b0, 1'b0);
    check_frame(1, 1'b0, 16'h0);

    // Input change while digit 2 is lit must not tear the current frame.
    din = 16'h1111;
    do_reset();
    push_frame(16'h1111, 4'h0, 4'hF, 1'b1, 1'b0);
    check_frame(0, 1'b1, 16'h2222);
    push_frame(16'h2222, 4'h0, 4'hF, 1'b1, 1'b0);
    check_frame(0, 1'b0, 16'h0);

    // Leading-zero blanking, dp on a blanked digit, and per-digit enable.
    din   = 16'h0050;
    dp_in = 4'b1000;
    do_reset();
    push_frame(16'h0050, 4'b1000, 4'hF, 1'b1, 1'b1);
    check_frame(2, 1'b0, 16'h0);
    din = 16'h0000;
    push_frame(16'h0050, 4'b1000, 4'hF, 1'b1, 1'b1);
    check_frame(2, 1'b0, 16'h0);
    push_frame(16'h0000, 4'b1000, 4'hF, 1'b1, 1'b1);
    check_frame(2, 1'b0, 16'h0);
    digit_en = 4'b1110;
    push_frame(16'h0000, 4'b1000, 4'hF, 1'b1, 1'b1);
    check_frame(2, 1'b0, 16'h0);
    push_frame(16'h0000, 4'b1000, 4'b1110, 1'b1, 1'b1);
    check_frame(2, 1'b0, 16'h0);

    // Reset during digit 2, restart at digit 0, then inverted pins in operation.
    din      = 16'h1234;
    dp_in    = 4'b0100;
    digit_en = 4'hF;
    do_reset();
    push_frame(16'h1234, 4'b0100, 4'hF, 1'b1, 1'b0);
    check_frame(0, 1'b0, 16'h0);
    repeat (12) @(negedge clk);
    chk("pre_rst_dig2", 32'(dig_o[0]), 32'h4);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_dig", 32'(dig_o[0]), 32'h0);
    chk("mid_rst_seg", 32'(seg_o[0]), 32'h0);
    chk("mid_rst_inv_dig", 32'(dig_o[3]), 32'hF);
    rst = 1'b0;
    @(negedge clk);
    chk("restart_tick", 32'(ft_o[0]), 32'd1);
    push_frame(16'h1234, 4'b0100, 4'hF, 1'b1, 1'b0);
    check_frame(0, 1'b0, 16'h0);
    push_frame(16'h1234, 4'b0100, 4'hF, 1'b1, 1'b0);
    check_frame(3, 1'b0, 16'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
